// File: rtl/bcd_to_binary_if.sv
// Request/result bundle for the sequential four-digit BCD to binary converter.
// The requester drives start/bcd_in and the converter returns binary, done, busy and error.
interface bcd_to_binary_if;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] binary;
    logic        done;
    logic        busy;
    logic        error;

    modport master (
        output start,
        output bcd_in,
        input  binary,
        input  done,
        input  busy,
        input  error
    );

    modport slave (
        input  start,
        input  bcd_in,
        output binary,
        output done,
        output busy,
        output error
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential BCD to binary converter: one digit per cycle, MSD first, 4-cycle latency.
// Define BCD_TO_BINARY_CHECK_EN to reject digits above 9 with a done+error pulse.
module bcd_to_binary (
    input  logic            clk,
    input  logic            rst,
    bcd_to_binary_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]  state;
    logic [15:0] digits;
    logic [13:0] acc;
    logic [1:0]  cnt;
    logic [13:0] binary_q;
    logic        done_q;
    logic        busy_q;
    logic [13:0] acc_next;

    // acc*10 built from shifts; every term is kept to 14 bits so the sum wraps mod 16384
    function automatic logic [13:0] mul10_add(input logic [13:0] a, input logic [3:0] d);
        logic [13:0] a8;
        logic [13:0] a2;
        a8 = a << 3;
        a2 = a << 1;
        return a8 + a2 + {10'd0, d};
    endfunction

    assign acc_next = mul10_add(acc, digits[15:12]);

`ifdef BCD_TO_BINARY_CHECK_EN
    logic error_q;
    logic bad_pend;
    logic has_bad;

    function automatic logic any_digit_invalid(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
               (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
    endfunction

    assign has_bad = any_digit_invalid(bus.bcd_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            digits   <= '0;
            acc      <= '0;
            cnt      <= '0;
            binary_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
            bad_pend <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bad_pend) begin
                        // rejected request reports one cycle after capture, binary untouched
                        done_q   <= 1'b1;
                        error_q  <= 1'b1;
                        bad_pend <= 1'b0;
                    end else if (bus.start) begin
                        digits  <= bus.bcd_in;
                        acc     <= '0;
                        cnt     <= '0;
                        error_q <= 1'b0;
                        if (has_bad) begin
                            bad_pend <= 1'b1;
                        end else begin
                            state  <= CONV;
                            busy_q <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    acc    <= acc_next;
                    digits <= digits << 4;
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        binary_q <= acc_next;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.error = error_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            digits   <= '0;
            acc      <= '0;
            cnt      <= '0;
            binary_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        digits <= bus.bcd_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CONV;
                        busy_q <= 1'b1;
                    end
                end
                CONV: begin
                    // nibbles above 9 are accumulated at face value
                    acc    <= acc_next;
                    digits <= digits << 4;
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        binary_q <= acc_next;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.error = 1'b0;
`endif

    assign bus.binary = binary_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: latency, hold behaviour, start masking, reset abort, invalid digits.
module tb_bcd_to_binary;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [13:0] last_bin;

    bcd_to_binary_if bus ();

    bcd_to_binary dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start at edge N, scramble bcd_in during CONV, expect done at N+4 and quiet at N+5
    task automatic run_conv(input string tag, input logic [15:0] bcd, input logic [13:0] exp);
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.bcd_in = ~bcd;
        check({tag, " busy@N"}, {15'd0, bus.busy}, 16'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check({tag, " busy mid"}, {15'd0, bus.busy}, 16'd1);
            check({tag, " done mid"}, {15'd0, bus.done}, 16'd0);
            check({tag, " binary held"}, {2'd0, bus.binary}, {2'd0, last_bin});
        end
        tick();
        check({tag, " done@N+4"}, {15'd0, bus.done}, 16'd1);
        check({tag, " busy@N+4"}, {15'd0, bus.busy}, 16'd0);
        check({tag, " binary"}, {2'd0, bus.binary}, {2'd0, exp});
        check({tag, " error"}, {15'd0, bus.error}, 16'd0);
        last_bin = exp;
        tick();
        check({tag, " done@N+5"}, {15'd0, bus.done}, 16'd0);
        check({tag, " binary hold"}, {2'd0, bus.binary}, {2'd0, exp});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_bin  = 14'd0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.bcd_in = 16'h0000;
        #2 rst = 1'b1;
        bus.start  = 1'b1;
        bus.bcd_in = 16'h1234;
        tick();
        tick();
        check("reset binary", {2'd0, bus.binary}, 16'd0);
        check("reset done",   {15'd0, bus.done},  16'd0);
        check("reset busy",   {15'd0, bus.busy},  16'd0);
        check("reset error",  {15'd0, bus.error}, 16'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        tick();

        run_conv("c1234", 16'h1234, 14'h04D2);
        run_conv("c9999", 16'h9999, 14'h270F);
        run_conv("c0000", 16'h0000, 14'h0000);
        run_conv("c0001", 16'h0001, 14'h0001);

        // second start during CONV must be ignored; restart in the done cycle is accepted
        bus.bcd_in = 16'h0042;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        bus.bcd_in = 16'h0777;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        check("mask done early", {15'd0, bus.done}, 16'd0);
        tick();
        check("mask done", {15'd0, bus.done}, 16'd1);
        check("mask binary", {2'd0, bus.binary}, 16'h002A);
        last_bin = 14'h002A;
        bus.bcd_in = 16'h0777;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check("restart busy", {15'd0, bus.busy}, 16'd1);
        check("restart done low", {15'd0, bus.done}, 16'd0);
        for (int i = 0; i < 3; i++) tick();
        check("restart binary held", {2'd0, bus.binary}, 16'h002A);
        tick();
        check("restart done", {15'd0, bus.done}, 16'd1);
        check("restart binary", {2'd0, bus.binary}, 16'h0309);
        last_bin = 14'h0309;
        tick();

`ifdef BCD_TO_BINARY_CHECK_EN
        bus.bcd_in = 16'h12A4;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check("bad busy@N", {15'd0, bus.busy}, 16'd0);
        check("bad done@N", {15'd0, bus.done}, 16'd0);
        tick();
        check("bad done@N+1",  {15'd0, bus.done},  16'd1);
        check("bad error@N+1", {15'd0, bus.error}, 16'd1);
        check("bad busy@N+1",  {15'd0, bus.busy},  16'd0);
        check("bad binary",    {2'd0, bus.binary}, {2'd0, last_bin});
        tick();
        check("bad done pulse", {15'd0, bus.done}, 16'd0);
        check("bad error sticky", {15'd0, bus.error}, 16'd1);
        run_conv("after bad", 16'h0015, 14'h000F);
`else
        run_conv("cFFFF", 16'hFFFF, 14'h0119);
`endif

        // abort mid-conversion with reset, start held during reset is ignored
        bus.bcd_in = 16'h5678;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("abort binary", {2'd0, bus.binary}, 16'd0);
        check("abort busy",   {15'd0, bus.busy},  16'd0);
        check("abort done",   {15'd0, bus.done},  16'd0);
        check("abort error",  {15'd0, bus.error}, 16'd0);
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst done low", {15'd0, bus.done}, 16'd0);
            check("rst busy low", {15'd0, bus.busy}, 16'd0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        check("post rst idle", {15'd0, bus.busy}, 16'd0);
        last_bin = 14'd0;
        run_conv("c5678", 16'h5678, 14'h162E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
